uart_fifo: RTL

Parametrised successor to the fixed 8N1/9600 UART on the 6502 peripheral bus. It has configurable data bits, parity, stop bits and baud, plus TX and RX FIFOs. RX uses 16× oversampling with majority voting and reports sticky framing, parity and overrun errors. It runs on a single clock domain and sits behind the same chip-select register interface, with a maskable interrupt to the CPU.

---
 rtl/uart_fifo_if.sv | 18 +
 rtl/uart_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_if.sv
// uart_fifo_if: chip-select register bus between the CPU side and uart_fifo.
//   cs       access strobe, one access per cycle while high
//   rw       1 = read, 0 = write
//   addr     register select (0 data, 1 status, 2 control, 3 reserved)
//   data_in  write data
//   data_out registered read data
//   irq      level interrupt to the CPU
interface uart_fifo_if;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  modport master (output cs, rw, addr, data_in, input data_out, irq);
  modport slave  (input cs, rw, addr, data_in, output data_out, irq);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: parametrised UART with TX/RX FIFOs, 16x oversampled receiver
// with 7/8/9 majority voting, sticky error flags and a maskable interrupt.
// Ports:
//   clk   sole clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   register interface (uart_fifo_if.slave)
//   RXD   asynchronous serial input
//   TXD   serial output, idles high
module uart_fifo #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_fifo_if.slave  bus,
  input  logic        RXD,
  output logic        TXD
);
  localparam int DIV = CLK_FREQ / (16 * BAUD) - 1;
  localparam int DW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [DW-1:0] DIV_L     = DW'(DIV);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Parity bit that makes data+parity odd (PARITY=1) or even (PARITY=2).
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    par_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------- register bus decode ----------------
  logic w_wr, w_rd, w_tx_push, w_rx_pop, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [2:0] w_w1c;
  assign w_wr      = bus.cs & ~bus.rw;
  assign w_rd      = bus.cs & bus.rw;
  assign w_tx_push = w_wr & (bus.addr == 2'd0) & ~w_tx_full;
  assign w_rx_pop  = w_rd & (bus.addr == 2'd0) & ~w_rx_empty;
  assign w_w1c     = (w_wr && bus.addr == 2'd1) ? bus.data_in[5:3] : 3'b000;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TAW:0] r_tx_wp, r_tx_rp;
  logic [DATA_BITS-1:0] w_tx_head;
  logic w_tx_pop;
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) && (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[TAW-1:0]];

  always_ff @(posedge clk)
    if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= bus.data_in[DATA_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
    end

  // ---------------- TX FSM ----------------
  state_t r_tx_st, w_tx_nx;
  logic [DW-1:0] r_tx_div;
  logic [3:0] r_tx_tick;
  logic [2:0] r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic r_tx_par, r_txd, w_tx_line, w_tx_tick, w_tx_bit_end;
  assign w_tx_tick    = (r_tx_div == DIV_L);
  assign w_tx_bit_end = w_tx_tick && (r_tx_tick == 4'd15);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tx_st <= S_IDLE;
    else        r_tx_st <= w_tx_nx;

  always_comb begin
    w_tx_nx = r_tx_st;
    case (r_tx_st)
      S_IDLE:  if (!w_tx_empty) w_tx_nx = S_START;
      S_START: if (w_tx_bit_end) w_tx_nx = S_DATA;
      S_DATA:  if (w_tx_bit_end && r_tx_bit == LAST_DATA) w_tx_nx = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_tx_bit_end) w_tx_nx = S_STOP;
      S_STOP:  if (w_tx_bit_end && r_tx_bit == LAST_STOP) w_tx_nx = w_tx_empty ? S_IDLE : S_START;
      default: w_tx_nx = S_IDLE;
    endcase
  end

  // A pop happens from IDLE or straight out of the last stop bit, so frames
  // queued in the FIFO go out with no idle gap.
  always_comb begin
    w_tx_pop  = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_st)
      S_IDLE:  w_tx_pop = ~w_tx_empty;
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = r_tx_shift[0];
      S_PAR:   w_tx_line = r_tx_par;
      S_STOP:  w_tx_pop = w_tx_bit_end && (r_tx_bit == LAST_STOP) && !w_tx_empty;
      default: w_tx_line = 1'b1;
    endcase
  end

  // TXD is registered, so the line lags the FSM state by one clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_div   <= '0;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_txd <= w_tx_line;
      if (w_tx_pop) begin
        r_tx_div   <= '0;
        r_tx_tick  <= '0;
        r_tx_bit   <= '0;
        r_tx_shift <= w_tx_head;
        r_tx_par   <= par_bit(w_tx_head);
      end else if (r_tx_st != S_IDLE) begin
        r_tx_div <= w_tx_tick ? '0 : r_tx_div + 1'b1;
        if (w_tx_tick) r_tx_tick <= r_tx_tick + 1'b1;
        if (w_tx_bit_end) begin
          if (r_tx_st == S_DATA) r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit <= (w_tx_nx != r_tx_st) ? 3'd0 : r_tx_bit + 1'b1;
        end
      end
    end

  assign TXD = r_txd;

  // ---------------- RX synchroniser + FSM ----------------
  logic r_rx_s1, r_rx_s2, r_rx_s3, w_rx_fall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
    else        {r_rx_s1, r_rx_s2, r_rx_s3} <= {RXD, r_rx_s1, r_rx_s2};
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  state_t r_rx_st, w_rx_nx;
  logic [DW-1:0] r_rx_div;
  logic [3:0] r_rx_tick;
  logic [2:0] r_rx_bit;
  logic [1:0] r_rx_samp;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic r_rx_perr, w_rx_tick, w_rx_bit_end, w_rx_s9, w_rx_maj, w_rx_push;
  assign w_rx_tick    = (r_rx_div == DIV_L);
  assign w_rx_bit_end = w_rx_tick && (r_rx_tick == 4'd15);
  assign w_rx_s9      = w_rx_tick && (r_rx_tick == 4'd9);
  // Majority of the tick 7/8 samples and the live tick-9 sample.
  assign w_rx_maj = (r_rx_samp[0] & r_rx_samp[1]) | (r_rx_samp[0] & r_rx_s2) | (r_rx_samp[1] & r_rx_s2);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rx_st <= S_IDLE;
    else        r_rx_st <= w_rx_nx;

  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      S_IDLE:  if (w_rx_fall) w_rx_nx = S_START;
      S_START: if (w_rx_s9 && w_rx_maj) w_rx_nx = S_IDLE;
               else if (w_rx_bit_end) w_rx_nx = S_DATA;
      S_DATA:  if (w_rx_bit_end && r_rx_bit == LAST_DATA) w_rx_nx = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_rx_bit_end) w_rx_nx = S_STOP;
      S_STOP:  if (w_rx_s9) w_rx_nx = S_IDLE;
      default: w_rx_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_push = 1'b0;
    if (r_rx_st == S_STOP) w_rx_push = w_rx_s9;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_div   <= '0;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_samp  <= 2'b11;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
    end else if (r_rx_st == S_IDLE) begin
      if (w_rx_fall) begin
        r_rx_div  <= '0;
        r_rx_tick <= '0;
        r_rx_bit  <= '0;
        r_rx_perr <= 1'b0;
      end
    end else begin
      r_rx_div <= w_rx_tick ? '0 : r_rx_div + 1'b1;
      if (w_rx_tick) begin
        r_rx_tick <= r_rx_tick + 1'b1;
        if (r_rx_tick == 4'd7) r_rx_samp[0] <= r_rx_s2;
        if (r_rx_tick == 4'd8) r_rx_samp[1] <= r_rx_s2;
      end
      if (w_rx_s9 && r_rx_st == S_DATA) r_rx_shift <= {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
      if (w_rx_s9 && r_rx_st == S_PAR)  r_rx_perr  <= (par_bit(r_rx_shift) != w_rx_maj);
      if (w_rx_bit_end) r_rx_bit <= (w_rx_nx != r_rx_st) ? 3'd0 : r_rx_bit + 1'b1;
    end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
  logic [RAW:0] r_rx_wp, r_rx_rp;
  logic [7:0] w_rx_head8;
  logic w_rx_wr;
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) && (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
  // A simultaneous CPU pop frees the slot, so a push into a full FIFO still lands.
  assign w_rx_wr    = w_rx_push & (~w_rx_full | w_rx_pop);

  always_comb begin
    w_rx_head8 = 8'h00;
    w_rx_head8[DATA_BITS-1:0] = r_rx_mem[r_rx_rp[RAW-1:0]];
  end

  always_ff @(posedge clk)
    if (w_rx_wr) r_rx_mem[r_rx_wp[RAW-1:0]] <= r_rx_shift;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
    end

  // ---------------- status / control / read data ----------------
  logic r_ovr, r_fe, r_pe;
  logic [2:0] r_ctrl;
  logic [7:0] r_data_out, w_status;
  logic w_tx_idle;
  assign w_tx_idle = w_tx_empty && (r_tx_st == S_IDLE);
  assign w_status  = {r_rx_st != S_IDLE, w_rx_full, r_pe, r_fe, r_ovr,
                      w_tx_idle, ~w_rx_empty, ~w_tx_full};

  // Error setting takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ovr      <= 1'b0;
      r_fe       <= 1'b0;
      r_pe       <= 1'b0;
      r_ctrl     <= 3'b000;
      r_data_out <= 8'h00;
    end else begin
      r_ovr <= (w_rx_push & w_rx_full & ~w_rx_pop) | (r_ovr & ~w_w1c[0]);
      r_fe  <= (w_rx_push & ~w_rx_maj)             | (r_fe  & ~w_w1c[1]);
      r_pe  <= (w_rx_push & r_rx_perr)             | (r_pe  & ~w_w1c[2]);
      if (w_wr && bus.addr == 2'd2) r_ctrl <= bus.data_in[2:0];
      if (w_rd) begin
        case (bus.addr)
          2'd0:    r_data_out <= w_rx_empty ? 8'h00 : w_rx_head8;
          2'd1:    r_data_out <= w_status;
          2'd2:    r_data_out <= {5'b00000, r_ctrl};
          default: r_data_out <= 8'h00;
        endcase
      end
    end

  assign bus.data_out = r_data_out;
  assign bus.irq = (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle) |
                   (r_ctrl[2] & (r_ovr | r_fe | r_pe));
endmodule
